// File: rtl/core_pkg.sv
// Shared decode types for the stage-2 decode pipe: opcodes, formats, ALU ops,
// pipe FSM states and the per-lane decode result.
package core_pkg;
  localparam int DECODE_MAX_LANES = 2;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'h03,
    OPC_CUSTOM_0 = 7'h0B,
    OPC_MISC_MEM = 7'h0F,
    OPC_OP_IMM   = 7'h13,
    OPC_AUIPC    = 7'h17,
    OPC_STORE    = 7'h23,
    OPC_AMO      = 7'h2F,
    OPC_OP       = 7'h33,
    OPC_LUI      = 7'h37,
    OPC_BRANCH   = 7'h63,
    OPC_JALR     = 7'h67,
    OPC_JAL      = 7'h6F,
    OPC_SYSTEM   = 7'h73
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_OTHER
  } instr_format_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } aluop_e;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} pipe_state_e;

  typedef struct packed {
    logic          illegal;
    logic          halt_req;
    logic [31:0]   imm;
    instr_format_e fmt;
    aluop_e        alu_op;
  } decode_lane_s;
endpackage

// File: rtl/core_s2_decode_pipe_lane.sv
// Combinational RV32I decode of one instruction lane.
// Extra illegal-encoding checks are enabled by CORE_S2_DECODE_STRICT_EN.
module core_s2_decode_lane
  import core_pkg::*;
(
  input  logic [31:0]  instr_i,
  output decode_lane_s dec_o
);
  opcode_e    opc;
  logic [2:0] f3;
  logic       known, strict_bad;

  assign opc = opcode_e'(instr_i[6:0]);
  assign f3  = instr_i[14:12];

  always_comb begin
    known        = 1'b1;
    dec_o.fmt    = FMT_OTHER;
    dec_o.alu_op = ALU_ADD;
    case (opc)
      OPC_OP, OPC_AMO:                               dec_o.fmt = FMT_R;
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR: dec_o.fmt = FMT_I;
      OPC_STORE:                                     dec_o.fmt = FMT_S;
      OPC_BRANCH:                                    dec_o.fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                            dec_o.fmt = FMT_U;
      OPC_JAL:                                       dec_o.fmt = FMT_J;
      OPC_CUSTOM_0, OPC_SYSTEM:                      dec_o.fmt = FMT_OTHER;
      default:                                       known = 1'b0;
    endcase

    if (opc == OPC_BRANCH) dec_o.alu_op = ALU_SUB;
    else if (opc == OPC_OP || opc == OPC_OP_IMM) begin
      case (f3)
        3'd0:    dec_o.alu_op = (opc == OPC_OP && instr_i[30]) ? ALU_SUB : ALU_ADD;
        3'd1:    dec_o.alu_op = ALU_SLL;
        3'd2:    dec_o.alu_op = ALU_SLT;
        3'd3:    dec_o.alu_op = ALU_SLTU;
        3'd4:    dec_o.alu_op = ALU_XOR;
        3'd5:    dec_o.alu_op = instr_i[30] ? ALU_SRA : ALU_SRL;
        3'd6:    dec_o.alu_op = ALU_OR;
        default: dec_o.alu_op = ALU_AND;
      endcase
    end

    case (dec_o.fmt)
      FMT_I:   dec_o.imm = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   dec_o.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   dec_o.imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   dec_o.imm = {instr_i[31:12], 12'b0};
      FMT_J:   dec_o.imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
      default: dec_o.imm = 32'h0;
    endcase
  end

`ifdef CORE_S2_DECODE_STRICT_EN
  always_comb begin
    strict_bad = 1'b0;
    case (opc)
      OPC_OP:     strict_bad = !(instr_i[31:25] inside {7'b0000000, 7'b0100000, 7'b0000001});
      OPC_LOAD:   strict_bad = f3 inside {3'd3, 3'd6, 3'd7};
      OPC_STORE:  strict_bad = f3 > 3'd2;
      OPC_BRANCH: strict_bad = f3 inside {3'd2, 3'd3};
      OPC_JALR:   strict_bad = f3 != 3'd0;
      default:    strict_bad = 1'b0;
    endcase
  end
`else
  assign strict_bad = 1'b0;
`endif

  // All supported opcodes end in 2'b11, but the explicit check keeps intent obvious.
  assign dec_o.illegal  = !known || instr_i[1:0] != 2'b11 || instr_i == 32'h0 ||
                          instr_i == 32'hFFFF_FFFF || strict_bad;
  assign dec_o.halt_req = opc == OPC_CUSTOM_0;
endmodule

// File: rtl/core_s2_decode_pipe.sv
// Stage-2 decode pipe: per-lane decode, BUF_DEPTH bundle FIFO and RUN/DRAIN/HALTED FSM.
// Define CORE_S2_DECODE_STRICT_EN for additional funct3/funct7 illegal checks.
module core_s2_decode_pipe
  import core_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int BUF_DEPTH = 2
)(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   resume,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES*32-1:0]                    in_instr,
  input  logic [31:0]                            in_pc,
  input  logic [LANES-1:0]                       in_lane_valid,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*32-1:0]                    out_instr,
  output logic [31:0]                            out_pc,
  output logic [LANES-1:0]                       out_lane_valid,
  output logic [LANES-1:0]                       out_illegal,
  output logic [LANES-1:0]                       out_halt_req,
  output logic [LANES*32-1:0]                    out_imm,
  output logic [LANES*$bits(instr_format_e)-1:0] out_format,
  output logic [LANES*$bits(aluop_e)-1:0]        out_alu_op,
  output logic                                   halted
);
  localparam int FW = $bits(instr_format_e);
  localparam int AW = $bits(aluop_e);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  decode_lane_s [LANES-1:0] dec, dec_rd;
  logic [LANES-1:0]         stop, halt_vec, lv_masked;
  logic                     push, pop;

  logic [LANES*32-1:0]      instr_q [BUF_DEPTH];
  logic [31:0]              pc_q    [BUF_DEPTH];
  logic [LANES-1:0]         lv_q    [BUF_DEPTH];
  decode_lane_s [LANES-1:0] dec_q   [BUF_DEPTH];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q;
  pipe_state_e              state_q, state_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    core_s2_decode_lane u_dec (.instr_i(in_instr[i*32 +: 32]), .dec_o(dec[i]));
    assign stop[i]     = in_lane_valid[i] & (dec[i].illegal | dec[i].halt_req);
    assign halt_vec[i] = dec[i].halt_req;

    assign out_illegal[i]         = dec_rd[i].illegal;
    assign out_halt_req[i]        = dec_rd[i].halt_req;
    assign out_imm[i*32 +: 32]    = dec_rd[i].imm;
    assign out_format[i*FW +: FW] = dec_rd[i].fmt;
    assign out_alu_op[i*AW +: AW] = dec_rd[i].alu_op;
  end

  // The first stopping lane survives; everything after it in the bundle is squashed.
  always_comb begin
    logic blk;
    blk = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lv_masked[i] = in_lane_valid[i] & !blk;
      blk          = blk | stop[i];
    end
  end

  assign in_ready  = (count_q < CW'(BUF_DEPTH)) && state_q == ST_RUN && !flush && !rst;
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < BUF_DEPTH; e++) begin
        instr_q[e] <= '0;
        pc_q[e]    <= '0;
        lv_q[e]    <= '0;
        dec_q[e]   <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= in_instr;
      pc_q[wr_ptr_q]    <= in_pc;
      lv_q[wr_ptr_q]    <= lv_masked;
      dec_q[wr_ptr_q]   <= dec;
    end
  end

  assign dec_rd         = dec_q[rd_ptr_q];
  assign out_instr      = instr_q[rd_ptr_q];
  assign out_pc         = pc_q[rd_ptr_q];
  assign out_lane_valid = lv_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_RUN;
    else begin
      case (state_q)
        ST_RUN:    if (push && |(lv_masked & halt_vec)) state_d = ST_DRAIN;
        ST_DRAIN:  if (count_q == '0) state_d = ST_HALTED;
        ST_HALTED: if (resume) state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  assign halted = state_q == ST_HALTED;
endmodule

// File: tb/tb_core_s2_decode_pipe.sv
// Directed bench for core_s2_decode_pipe (LANES=2, BUF_DEPTH=2): decode table plus FIFO/FSM sequences.
module tb_core_s2_decode_pipe;
  import core_pkg::*;
  localparam int L  = 2;
  localparam int D  = 2;
  localparam int FW = $bits(instr_format_e);
  localparam int AW = $bits(aluop_e);
`ifdef CORE_S2_DECODE_STRICT_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush, resume, in_valid, in_ready, out_valid, out_ready, halted;
  logic [L*32-1:0] in_instr, out_instr, out_imm;
  logic [31:0]     in_pc, out_pc;
  logic [L-1:0]    in_lane_valid, out_lane_valid, out_illegal, out_halt_req;
  logic [L*FW-1:0] out_format;
  logic [L*AW-1:0] out_alu_op;

  core_s2_decode_pipe #(.LANES(L), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .resume(resume),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_lane_valid(in_lane_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_lane_valid(out_lane_valid),
    .out_illegal(out_illegal), .out_halt_req(out_halt_req), .out_imm(out_imm),
    .out_format(out_format), .out_alu_op(out_alu_op), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0]   instr;
    logic          ill;
    logic [31:0]   imm;
    instr_format_e fmt;
    aluop_e        alu;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h00500093, 1'b0,   32'h00000005, FMT_I,     ALU_ADD};
    tbl[1]  = '{32'h12345037, 1'b0,   32'h12345000, FMT_U,     ALU_ADD};
    tbl[2]  = '{32'h00000000, 1'b1,   32'h00000000, FMT_OTHER, ALU_ADD};
    tbl[3]  = '{32'hFFFFFFFF, 1'b1,   32'h00000000, FMT_OTHER, ALU_ADD};
    tbl[4]  = '{32'h40208133, 1'b0,   32'h00000000, FMT_R,     ALU_SUB};
    tbl[5]  = '{32'h4050D093, 1'b0,   32'h00000405, FMT_I,     ALU_SRA};
    tbl[6]  = '{32'hFE010EE3, 1'b0,   32'hFFFFFFFC, FMT_B,     ALU_SUB};
    tbl[7]  = '{32'h00512423, 1'b0,   32'h00000008, FMT_S,     ALU_ADD};
    tbl[8]  = '{32'h001000EF, 1'b0,   32'h00000800, FMT_J,     ALU_ADD};
    tbl[9]  = '{32'h0000F083, STRICT, 32'h00000000, FMT_I,     ALU_ADD};
    tbl[10] = '{32'h00001097, 1'b0,   32'h00001000, FMT_U,     ALU_ADD};
    tbl[11] = '{32'h00000011, 1'b1,   32'h00000000, FMT_OTHER, ALU_ADD};
    tbl[12] = '{32'h00000073, 1'b0,   32'h00000000, FMT_OTHER, ALU_ADD};
    tbl[13] = '{32'hFFF02093, 1'b0,   32'hFFFFFFFF, FMT_I,     ALU_SLT};

    flush = 0; resume = 0; in_valid = 0; out_ready = 0;
    in_instr = '0; in_pc = '0; in_lane_valid = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out_instr", out_instr, 0);
    rst = 0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // Decode table: one lane-0 bundle each, popped the cycle after it appears
    out_ready = 1;
    foreach (tbl[k]) begin
      in_instr      = {32'h00000013, tbl[k].instr};
      in_lane_valid = 2'b01;
      in_pc         = 32'h1000 + 32'(k * 8);
      in_valid      = 1;
      #1 chk($sformatf("v%0d_in_ready", k), in_ready, 1);
      tick();
      in_valid = 0;
      chk($sformatf("v%0d_out_valid", k), out_valid, 1);
      chk($sformatf("v%0d_instr", k), out_instr[31:0], tbl[k].instr);
      chk($sformatf("v%0d_pc", k), out_pc, 32'h1000 + 32'(k * 8));
      chk($sformatf("v%0d_lane_valid", k), out_lane_valid, 2'b01);
      chk($sformatf("v%0d_illegal", k), out_illegal[0], tbl[k].ill);
      chk($sformatf("v%0d_halt", k), out_halt_req[0], 0);
      chk($sformatf("v%0d_imm", k), out_imm[31:0], tbl[k].imm);
      chk($sformatf("v%0d_fmt", k), out_format[FW-1:0], tbl[k].fmt);
      chk($sformatf("v%0d_alu", k), out_alu_op[AW-1:0], tbl[k].alu);
      tick();
      chk($sformatf("v%0d_drained", k), out_valid, 0);
    end

    // Backpressure: fill, hold stable, one pop frees a slot, order preserved
    out_ready = 0; in_lane_valid = 2'b01; in_valid = 1;
    in_instr = {32'h0, 32'h00100093};
    #1 chk("bp_rdy0", in_ready, 1);
    tick();
    in_instr = {32'h0, 32'h00200093};
    #1 chk("bp_rdy1", in_ready, 1);
    tick();
    in_instr = {32'h0, 32'h00300093};
    #1 chk("bp_full", in_ready, 0);
    chk("bp_head", out_instr[31:0], 32'h00100093);
    tick();
    chk("bp_full_hold", in_ready, 0);
    chk("bp_head_stable", out_instr[31:0], 32'h00100093);
    chk("bp_valid_stable", out_valid, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    #1 chk("bp_rdy_back", in_ready, 1);
    chk("bp_head2", out_instr[31:0], 32'h00200093);
    tick();
    in_valid = 0;
    chk("bp_head2_hold", out_instr[31:0], 32'h00200093);
    out_ready = 1;
    tick();
    chk("bp_head3", out_instr[31:0], 32'h00300093);
    tick();
    chk("bp_empty", out_valid, 0);

    // Halt on lane 1: DRAIN, then HALTED once empty, resume back to RUN
    out_ready = 0;
    in_instr = {32'h0000000B, 32'h00500093}; in_lane_valid = 2'b11; in_valid = 1;
    tick();
    in_valid = 0;
    #1 chk("h_halt_req", out_halt_req, 2'b10);
    chk("h_lane_valid", out_lane_valid, 2'b11);
    chk("h_drain_rdy", in_ready, 0);
    chk("h_not_halted", halted, 0);
    resume = 1;
    out_ready = 1;
    tick();
    resume = 0;
    out_ready = 0;
    chk("h_popped", out_valid, 0);
    chk("h_still_drain", halted, 0);
    chk("h_drain_rdy2", in_ready, 0);
    tick();
    chk("h_halted", halted, 1);
    chk("h_halted_rdy", in_ready, 0);
    tick();
    chk("h_halted_hold", halted, 1);
    resume = 1;
    tick();
    resume = 0;
    #1 chk("h_resumed", halted, 0);
    chk("h_resumed_rdy", in_ready, 1);

    // Halt on lane 0 squashes lane 1; flush out of DRAIN
    in_instr = {32'h00500093, 32'h0000000B}; in_lane_valid = 2'b11; in_valid = 1;
    tick();
    in_valid = 0;
    #1 chk("h0_lane_valid", out_lane_valid, 2'b01);
    chk("h0_halt_req", out_halt_req, 2'b01);
    chk("h0_drain_rdy", in_ready, 0);
    flush = 1;
    tick();
    flush = 0;
    #1 chk("h0_flush_valid", out_valid, 0);
    chk("h0_flush_rdy", in_ready, 1);
    chk("h0_flush_halted", halted, 0);

    // Illegal lane 0 squashes lane 1; flush beats a same-cycle push
    in_instr = {32'h00500093, 32'hFFFFFFFF}; in_lane_valid = 2'b11; in_valid = 1;
    tick();
    chk("il_lane_valid", out_lane_valid, 2'b01);
    chk("il_illegal", out_illegal, 2'b01);
    in_instr = {32'h0, 32'h00700093}; in_lane_valid = 2'b01; flush = 1;
    #1 chk("fl_rdy_low", in_ready, 0);
    tick();
    flush = 0; in_valid = 0;
    #1 chk("fl_out_valid", out_valid, 0);
    chk("fl_rdy", in_ready, 1);
    out_ready = 1;
    in_instr = {32'h0, 32'h00900093}; in_valid = 1;
    tick();
    in_valid = 0;
    chk("fl_after_push", out_instr[31:0], 32'h00900093);
    tick();
    chk("fl_after_pop", out_valid, 0);

    // Asynchronous reset mid-operation drops the buffered bundle
    out_ready = 0;
    in_instr = {32'h0, 32'h00500093}; in_lane_valid = 2'b01; in_valid = 1;
    tick();
    in_valid = 0;
    chk("ar_loaded", out_valid, 1);
    #2 rst = 1;
    #1 chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_data", out_instr, 0);
    chk("ar_imm", out_imm, 0);
    tick();
    rst = 0;
    #1 chk("ar_release_valid", out_valid, 0);
    chk("ar_release_rdy", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/core_s2_decode_pipe.md
CORE_S2_DECODE_PIPE -- requirements
Module: core_s2_decode_pipe

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter LANES, default 1, meaning instructions per bundle (legal 1..2).
REQ-003 SHALL have parameter BUF_DEPTH, default 2, meaning output buffer entries in bundles (power of two, 2..4).
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock
- rst  in  1  async active-high reset
- flush  in  1  discard all buffered bundles
- resume  in  1  leave HALTED
- in_valid  in  1  bundle offered
- in_ready  out  1  bundle accepted when in_valid&&in_ready
- in_instr  in  LANES*32  raw instructions; lane 0 in LSBs
- in_pc  in  32  lane-0 PC; lane i PC = in_pc+4*i
- in_lane_valid  in  LANES  per-lane valid
- out_valid  out  1  bundle available
- out_ready  in  1  consumer takes bundle
- out_instr, out_pc, out_lane_valid  out  as inputs  buffered copies
- out_illegal  out  LANES  lane illegal
- out_halt_req  out  LANES  lane is CUSTOM_0
- out_imm  out  LANES*32  decoded immediate
- out_format  out  LANES*$bits(instr_format_e)  format
- out_alu_op  out  LANES*$bits(aluop_e)  ALU op
- halted  out  1  FSM in HALTED

Function
REQ-005 SHALL decode each lane combinationally at input and write the result into a BUF_DEPTH-entry FIFO on accept; latency is exactly 1 cycle from accept to out_valid when the FIFO was empty.
REQ-006 SHALL drive in_ready = (count<BUF_DEPTH) && state==RUN && !flush, with no combinational path from out_ready.
REQ-007 SHALL, on simultaneous push and pop, keep count unchanged; pointers wrap modulo BUF_DEPTH.
REQ-008 SHALL hold out_* stable while out_valid && !out_ready.
REQ-009 SHALL flag a lane illegal when its opcode is unsupported, instr[1:0]!=2'b11, instr==32'h0, or instr==32'hFFFFFFFF; supported opcodes: LOAD, CUSTOM_0, MISC_MEM, OP_IMM, AUIPC, STORE, AMO, OP, LUI, BRANCH, JALR, JAL, SYSTEM.
REQ-010 SHALL select format: R for OP/AMO; I for LOAD/MISC_MEM/OP_IMM/JALR; S for STORE; B for BRANCH; U for LUI/AUIPC; J for JAL; OTHER for everything else.
REQ-011 SHALL produce a sign-extended immediate per RV32I encoding for formats I/S/B/U/J, and 0 for R/OTHER.
REQ-012 SHALL produce alu_op: ADD for LOAD/STORE/AUIPC/JAL/JALR/LUI; SUB for BRANCH; for OP/OP_IMM, derive from funct3, using funct7[5] for SUB (OP only) and SRA; ADD for all other opcodes.
REQ-013 SHALL clear lane_valid on every lane above the lowest valid lane that is illegal or halt_req; that lane itself stays valid.
REQ-014 SHALL implement states RUN, DRAIN, HALTED.
- RUN->DRAIN on accepting a bundle containing a valid halt_req lane.
- DRAIN->HALTED when count==0.
- HALTED->RUN on resume.
- resume ignored outside HALTED.
REQ-015 SHALL assert halted only in HALTED.
REQ-016 SHALL, on flush, empty the FIFO and enter RUN next cycle in any state; flush wins over a same-cycle push, pop and resume.

Reset
REQ-017 SHALL, while rst is high, force count=0, state=RUN, out_valid=0, in_ready=0, halted=0, and all FIFO data to 0.
REQ-018 SHALL, when rst asserts mid-operation, discard buffered bundles with no partial output.

Configuration
REQ-019 SHALL, when CORE_S2_DECODE_STRICT_EN is defined, also flag illegal:
- OP funct7 not in {0000000, 0100000, 0000001};
- LOAD funct3 in {3,6,7};
- STORE funct3>2;
- BRANCH funct3 in {2,3};
- JALR funct3!=0.
REQ-020 SHALL, without CORE_S2_DECODE_STRICT_EN, check only the REQ-009 conditions.

Structure
REQ-021 SHALL take opcode_e, instr_format_e, aluop_e, a decode_lane_s result struct, and DECODE_MAX_LANES=2 from core_pkg.
REQ-022 SHALL instantiate combinational sub-module core_s2_decode_lane once per lane; FIFO and FSM live in the top.

Verification
REQ-023 LANES=1, push 32'h00500093 with out_ready=1 -> next cycle out_valid=1, imm=5, format I, alu_op ADD, illegal=0.
REQ-024 LANES=1, push 32'h12345037 then 32'h00000000 -> imms 32'h12345000 and 0; illegal 0 then 1.
REQ-025 BUF_DEPTH=2, out_ready=0, push 3 bundles -> in_ready=0 after 2 accepts; one out_ready pulse restores in_ready next cycle.
REQ-026 LANES=2, bundle {32'h00500093, 32'h0000000B} (lane 0 first) -> halt_req lane 1, DRAIN; after pop halted=1, in_ready=0; resume -> RUN.
REQ-027 LANES=2, lane 0=32'hFFFFFFFF, lane 1 valid -> out_lane_valid=2'b01; flush with push same cycle -> out_valid=0 next cycle, count 0.
REQ-028 With STRICT_EN, push 32'h0000F083 (LOAD funct3=7) -> illegal=1; without STRICT_EN -> illegal=0.
